// File: rtl/uart_rx_framer_if.sv
// Signal bundle between the UART receive port, the framer and the payload consumer.
// master = framer side, slave = UART/consumer side.
interface uart_rx_framer_if;
  logic [7:0] rx_byte;
  logic       rx_ne;
  logic       rx_clear;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic [1:0] hs_state;
  logic [1:0] parse_state;

  modport master (
    input  rx_byte, rx_ne,
    output rx_clear, data, data_valid, frame_ok, frame_err, err_code, busy,
    output hs_state, parse_state
  );

  modport slave (
    output rx_byte, rx_ne,
    input  rx_clear, data, data_valid, frame_ok, frame_err, err_code, busy,
    input  hs_state, parse_state
  );
endinterface

// File: rtl/uart_rx_framer.sv
// Drains UART bytes via RXNE/clear, hunts for SYNC and parses length-prefixed
// frames with an additive checksum and an inter-byte timeout.
module uart_rx_framer #(
  parameter logic [7:0] SYNC        = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 104160
) (
  input logic               clk,
  input logic               rst_n,
  uart_rx_framer_if.master  bus
);
  // Handshake: a byte is consumed only in HS_IDLE with rx_ne=1. It is handed
  // to the parser that same cycle; rx_clear follows for one cycle, then a
  // gap cycle hides the UART's stale rx_ne.
  typedef enum logic [1:0] {HS_IDLE, HS_CLEAR, HS_GAP}      hs_t;
  typedef enum logic [1:0] {P_HUNT, P_LEN, P_PAYLOAD, P_CHK} p_t;

  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  hs_t hs_q, hs_n;
  p_t  p_q, p_n;

  logic [7:0]    rx_b;
  logic          consume, timeout_hit;
  logic [7:0]    len_q, len_n, sum_q, sum_n, cnt_q, cnt_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic [7:0]    data_q, data_n;
  logic          valid_q, valid_n, ok_q, ok_n, err_q, err_n;
  logic [1:0]    code_q, code_n;

  assign rx_b        = bus.rx_byte;
  assign consume     = (hs_q == HS_IDLE) && bus.rx_ne;
  assign timeout_hit = (p_q != P_HUNT) && !consume && (tcnt_q == TO_LAST);

  // State register plus registered datapath and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= HS_IDLE;
      p_q     <= P_HUNT;
      len_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      hs_q    <= hs_n;
      p_q     <= p_n;
      len_q   <= len_n;
      sum_q   <= sum_n;
      cnt_q   <= cnt_n;
      tcnt_q  <= tcnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ok_q    <= ok_n;
      err_q   <= err_n;
      code_q  <= code_n;
    end
  end

  // Next-state logic for both FSMs
  always_comb begin
    hs_n = hs_q;
    case (hs_q)
      HS_IDLE:  if (bus.rx_ne) hs_n = HS_CLEAR;
      HS_CLEAR: hs_n = HS_GAP;
      HS_GAP:   hs_n = HS_IDLE;
      default:  hs_n = HS_IDLE;
    endcase

    p_n = p_q;
    if (consume) begin
      case (p_q)
        P_HUNT:    if (rx_b == SYNC) p_n = P_LEN;
        P_LEN:     p_n = (rx_b == 8'd0 || rx_b > 8'(MAX_LEN)) ? P_HUNT : P_PAYLOAD;
        P_PAYLOAD: if (cnt_q + 8'd1 == len_q) p_n = P_CHK;
        P_CHK:     p_n = P_HUNT;
        default:   p_n = P_HUNT;
      endcase
    end else if (timeout_hit) begin
      p_n = P_HUNT;
    end
  end

  // Output/datapath next values
  always_comb begin
    len_n   = len_q;
    sum_n   = sum_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    code_n  = code_q;
    valid_n = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    tcnt_n  = (consume || p_q == P_HUNT) ? '0 : tcnt_q + TW'(1);

    if (consume) begin
      case (p_q)
        P_LEN: begin
          if (rx_b == 8'd0 || rx_b > 8'(MAX_LEN)) begin
            err_n  = 1'b1;
            code_n = 2'd1;
          end else begin
            len_n = rx_b;
            sum_n = rx_b;
            cnt_n = 8'd0;
          end
        end
        P_PAYLOAD: begin
          data_n  = rx_b;
          valid_n = 1'b1;
          sum_n   = sum_q + rx_b;
          cnt_n   = cnt_q + 8'd1;
        end
        P_CHK: begin
          if (rx_b == sum_q) begin
            ok_n = 1'b1;
          end else begin
            err_n  = 1'b1;
            code_n = 2'd2;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      err_n  = 1'b1;
      code_n = 2'd3;
    end
  end

  assign bus.rx_clear    = (hs_q == HS_CLEAR);
  assign bus.busy        = (p_q != P_HUNT);
  assign bus.data        = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_ok    = ok_q;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = code_q;
  assign bus.hs_state    = hs_q;
  assign bus.parse_state = p_q;
endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: UART byte-source model, stream-level frame model,
// event scoreboard, directed plus randomized frames.
module tb_uart_rx_framer;
  localparam logic [7:0] SYNC        = 8'hAA;
  localparam int         MAX_LEN     = 16;
  localparam int         TIMEOUT_CYC = 100;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_framer_if bus();

  uart_rx_framer #(.SYNC(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard events: {2'b00,data} / {2'b01,8'h00} ok / {2'b10,6'b0,code} err
  logic [9:0] exp_q[$];
  logic [7:0] uart_q[$];
  logic [7:0] stream[$];
  bit b2b = 1'b0;
  bit pending = 1'b0;
  int gap_cnt = 0;
  int clear_cnt = 0;
  int last_clear_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the byte stream frame by frame
  function automatic void model(input bit trailing_timeout);
    int i;
    logic [7:0] len, sum;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      if (i >= stream.size()) begin
        if (trailing_timeout) exp_q.push_back({2'b10, 8'd3});
        return;
      end
      len = stream[i];
      i++;
      if (len == 8'd0 || int'(len) > MAX_LEN) begin
        exp_q.push_back({2'b10, 8'd1});
        continue;
      end
      sum = len;
      for (int k = 0; k < int'(len); k++) begin
        if (i >= stream.size()) begin
          if (trailing_timeout) exp_q.push_back({2'b10, 8'd3});
          return;
        end
        exp_q.push_back({2'b00, stream[i]});
        sum = sum + stream[i];
        i++;
      end
      if (i >= stream.size()) begin
        if (trailing_timeout) exp_q.push_back({2'b10, 8'd3});
        return;
      end
      exp_q.push_back(stream[i] == sum ? {2'b01, 8'h00} : {2'b10, 8'd2});
      i++;
    end
  endfunction

  // UART model: RXNE drops one cycle after the clear (stale in the gap cycle);
  // in b2b mode the next byte replaces the old one at the clear itself.
  initial begin
    bus.rx_ne   = 1'b0;
    bus.rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        bus.rx_ne = 1'b0;
      end else if (bus.rx_clear) begin
        if (b2b && uart_q.size() > 0) bus.rx_byte = uart_q.pop_front();
        else pending = 1'b1;
      end else if (!bus.rx_ne && uart_q.size() > 0) begin
        if (gap_cnt == 0) begin
          bus.rx_byte = uart_q.pop_front();
          bus.rx_ne   = 1'b1;
          gap_cnt     = b2b ? 0 : int'($urandom_range(0, 3));
        end else begin
          gap_cnt--;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.rx_clear) begin
          clear_cnt++;
          last_clear_cyc = cyc;
        end
        if (bus.data_valid || bus.frame_ok || bus.frame_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {29'd0, bus.data_valid, bus.frame_ok, bus.frame_err}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (bus.frame_ok || bus.frame_err) begin
              check("ok_err_exclusive", {31'd0, bus.frame_ok & bus.frame_err}, 32'd0);
              check("busy_at_end", {31'd0, bus.busy}, 32'd0);
            end
            if (bus.data_valid)
              check("data", {22'd0, 2'b00, bus.data}, {22'd0, e});
            else if (bus.frame_ok)
              check("frame_ok", {22'd0, 2'b01, 8'h00}, {22'd0, e});
            else
              check("frame_err", {22'd0, 2'b10, 6'd0, bus.err_code}, {22'd0, e});
            if (bus.frame_err && e == {2'b10, 8'd3})
              check("timeout_latency", cyc - last_clear_cyc, TIMEOUT_CYC);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int extra);
    int t;
    t = 0;
    while (!(uart_q.size() == 0 && !bus.rx_ne && !pending && bus.hs_state == 2'd0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_bound", {31'd0, t < 20000}, 32'd1);
    repeat (extra) @(negedge clk);
  endtask

  task automatic run_stream(input bit use_b2b, input bit trailing_timeout);
    int n;
    model(trailing_timeout);
    n = stream.size();
    b2b = use_b2b;
    clear_cnt = 0;
    foreach (stream[j]) uart_q.push_back(stream[j]);
    wait_drain(trailing_timeout ? TIMEOUT_CYC + 20 : 8);
    check("clear_count", clear_cnt, n);
    check("exp_drained", exp_q.size(), 0);
    stream.delete();
  endtask

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[j]) stream.push_back(b[j]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_clear"},   {31'd0, bus.rx_clear},   32'd0);
    check({tag, "_data"},       {24'd0, bus.data},       32'd0);
    check({tag, "_data_valid"}, {31'd0, bus.data_valid}, 32'd0);
    check({tag, "_frame_ok"},   {31'd0, bus.frame_ok},   32'd0);
    check({tag, "_frame_err"},  {31'd0, bus.frame_err},  32'd0);
    check({tag, "_err_code"},   {30'd0, bus.err_code},   32'd0);
    check({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
  endtask

  task automatic random_frame();
    int g, len;
    logic [7:0] sum, b;
    g = $urandom_range(0, 2);
    for (int k = 0; k < g; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h55;
      stream.push_back(b);
    end
    stream.push_back(SYNC);
    len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 40)) * int'($urandom_range(0, 1))
                                      : int'($urandom_range(1, MAX_LEN));
    stream.push_back(8'(len));
    if (len == 0 || len > MAX_LEN) return;
    sum = 8'(len);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      stream.push_back(b);
      sum = sum + b;
    end
    if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
    stream.push_back(sum);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_hs_state", {30'd0, bus.hs_state}, 32'd0);
    check("reset_parse_state", {30'd0, bus.parse_state}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame, then bad checksum
    push_bytes('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    run_stream(1'b0, 1'b0);
    push_bytes('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68});
    run_stream(1'b0, 1'b0);
    check("err_code_held", {30'd0, bus.err_code}, 32'd2);

    // Resync through garbage and bad lengths
    push_bytes('{8'h55, 8'h00, 8'hAA, 8'h01, 8'h5A, 8'h5B, 8'hAA, 8'h00, 8'hAA, 8'h11});
    run_stream(1'b0, 1'b0);

    // Timeout, then recovery
    push_bytes('{8'hAA, 8'h02, 8'h10});
    run_stream(1'b0, 1'b1);
    check("err_code_timeout", {30'd0, bus.err_code}, 32'd3);
    push_bytes('{8'hAA, 8'h01, 8'h00, 8'h01});
    run_stream(1'b0, 1'b0);

    // Back-to-back max-length frame with wrap-around checksum
    push_bytes('{8'hAA, 8'h10});
    for (int k = 0; k < 16; k++) stream.push_back(8'hFF);
    stream.push_back(8'h00);
    run_stream(1'b1, 1'b0);

    // Reset in the middle of a frame
    push_bytes('{8'hAA, 8'h04, 8'h01});
    run_stream(1'b0, 1'b0);
    check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_bytes('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    run_stream(1'b0, 1'b0);

    // Randomized frames, alternating handshake pacing
    for (int batch = 0; batch < 8; batch++) begin
      for (int f = 0; f < 5; f++) random_frame();
      run_stream(batch[0], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
